// File: rtl/reg_wb_arbiter.sv
// Write-port arbiter for the register file: pipeline writeback has absolute priority,
// long-latency results queue in a small FIFO and drain into idle write slots.
module reg_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_wr_en,
    input  logic [ADDR_W-1:0] pipe_wr_addr,
    input  logic [DATA_W-1:0] pipe_wr_data,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_addr,
    input  logic [DATA_W-1:0] lu_data,
    input  logic [ADDR_W-1:0] query_addr1,
    input  logic [ADDR_W-1:0] query_addr2,
    output logic              pend1,
    output logic              pend2,
    output logic              stall_req,
    output logic              regwrite,
    output logic [ADDR_W-1:0] REG_address_wb,
    output logic [DATA_W-1:0] data_wb
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);

    logic [DEPTH-1:0]  live_q;
    logic [DEPTH-1:0]  live_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [AGE_W-1:0]  age_q;
    logic [AGE_W-1:0]  age_d;

    logic pipe_act;
    logic lu_xfer;
    logic push;
    logic pop;
    logic push_live;

    always_comb begin
        pipe_act  = pipe_wr_en && (pipe_wr_addr != '0);
        lu_ready  = (count_q < FULL_CNT);
        lu_xfer   = lu_valid && lu_ready;
        push      = lu_xfer && (lu_addr != '0);
        pop       = !pipe_act && (count_q != '0);
        // A same-cycle pipeline write to the same register is younger and wins.
        push_live = !(pipe_act && (lu_addr == pipe_wr_addr));
    end

    always_comb begin
        live_d = live_q;
        if (pop) begin
            live_d[head_q] = 1'b0;
        end
        if (pipe_act) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == pipe_wr_addr) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (push) begin
            live_d[tail_q] = push_live;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        age_d = '0;
        if ((count_q != '0) && !pop) begin
            age_d = (age_q == AGE_MAX) ? age_q : age_q + AGE_W'(1);
        end
    end

    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (addr_q[i] == query_addr1)) begin
                pend1 = 1'b1;
            end
            if (live_q[i] && (addr_q[i] == query_addr2)) begin
                pend2 = 1'b1;
            end
        end
        if (query_addr1 == '0) begin
            pend1 = 1'b0;
        end
        if (query_addr2 == '0) begin
            pend2 = 1'b0;
        end
    end

    // Payload storage needs no reset; live bits gate every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= lu_addr;
            data_q[tail_q] <= lu_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            age_q     <= '0;
            stall_req <= 1'b0;
        end else begin
            live_q    <= live_d;
            count_q   <= count_d;
            age_q     <= age_d;
            stall_req <= (age_q == AGE_MAX);
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regwrite       <= 1'b0;
            REG_address_wb <= '0;
            data_wb        <= '0;
        end else if (pipe_act) begin
            regwrite       <= 1'b1;
            REG_address_wb <= pipe_wr_addr;
            data_wb        <= pipe_wr_data;
        end else if (pop) begin
            regwrite       <= live_q[head_q];
            REG_address_wb <= addr_q[head_q];
            data_wb        <= data_q[head_q];
        end else begin
            regwrite <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: per-cycle vector table plus starvation and reset sequences.
module tb_reg_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        pipe_wr_en;
    logic [4:0]  pipe_wr_addr;
    logic [31:0] pipe_wr_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic [4:0]  query_addr1;
    logic [4:0]  query_addr2;
    logic        pend1;
    logic        pend2;
    logic        stall_req;
    logic        regwrite;
    logic [4:0]  REG_address_wb;
    logic [31:0] data_wb;

    int n_total;
    int n_pass;

    reg_wb_arbiter #(
        .DATA_W(32), .ADDR_W(5), .DEPTH(4), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .pipe_wr_en(pipe_wr_en), .pipe_wr_addr(pipe_wr_addr), .pipe_wr_data(pipe_wr_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
        .query_addr1(query_addr1), .query_addr2(query_addr2),
        .pend1(pend1), .pend2(pend2), .stall_req(stall_req),
        .regwrite(regwrite), .REG_address_wb(REG_address_wb), .data_wb(data_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pe;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rdy;
        logic        p1;
        logic        p2;
        logic        st;
    } vec_t;

    function automatic vec_t mk(int pe, int pa, int pd, int lv, int la, int ld, int q1, int q2,
                                int rw, int wa, int wd, int rdy, int p1, int p2, int st);
        vec_t v;
        v.pe = pe[0];  v.pa = pa[4:0]; v.pd = pd;
        v.lv = lv[0];  v.la = la[4:0]; v.ld = ld;
        v.q1 = q1[4:0]; v.q2 = q2[4:0];
        v.rw = rw[0];  v.wa = wa[4:0]; v.wd = wd;
        v.rdy = rdy[0]; v.p1 = p1[0]; v.p2 = p2[0]; v.st = st[0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        pipe_wr_en   = v.pe;
        pipe_wr_addr = v.pa;
        pipe_wr_data = v.pd;
        lu_valid     = v.lv;
        lu_addr      = v.la;
        lu_data      = v.ld;
        query_addr1  = v.q1;
        query_addr2  = v.q2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[29];

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset = 1'b0;
        drive(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0));

        //            pe pa pd           lv la ld       q1 q2  rw wa wd           rdy p1 p2 st
        vecs[0]  = mk(1, 5, 'hDEADBEEF,  0, 0, 0,       5, 0,  1, 5, 'hDEADBEEF,  1, 0, 0, 0);
        vecs[1]  = mk(1, 0, 'h123,       0, 0, 0,       0, 0,  0, 0, 0,           1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0,           0, 0, 0,       0, 0,  0, 0, 0,           1, 0, 0, 0);
        vecs[3]  = mk(1, 3, 'h31,        1, 7, 'h11,    7, 0,  1, 3, 'h31,        1, 1, 0, 0);
        vecs[4]  = mk(1, 3, 'h32,        0, 0, 0,       7, 0,  1, 3, 'h32,        1, 1, 0, 0);
        vecs[5]  = mk(1, 3, 'h33,        0, 0, 0,       7, 0,  1, 3, 'h33,        1, 1, 0, 0);
        vecs[6]  = mk(0, 0, 0,           0, 0, 0,       7, 0,  1, 7, 'h11,        1, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0,           0, 0, 0,       7, 0,  0, 0, 0,           1, 0, 0, 0);
        vecs[8]  = mk(1, 1, 'h100,       1, 10, 'hA0,   10, 13, 1, 1, 'h100,      1, 1, 0, 0);
        vecs[9]  = mk(1, 1, 'h101,       1, 11, 'hA1,   10, 13, 1, 1, 'h101,      1, 1, 0, 0);
        vecs[10] = mk(1, 1, 'h102,       1, 12, 'hA2,   10, 13, 1, 1, 'h102,      1, 1, 0, 0);
        vecs[11] = mk(1, 1, 'h103,       1, 13, 'hA3,   10, 13, 1, 1, 'h103,      0, 1, 1, 0);
        vecs[12] = mk(1, 1, 'h104,       1, 14, 'hA4,   14, 13, 1, 1, 'h104,      0, 0, 1, 0);
        vecs[13] = mk(0, 0, 0,           1, 14, 'hA4,   10, 13, 1, 10, 'hA0,      1, 0, 1, 0);
        vecs[14] = mk(0, 0, 0,           1, 14, 'hA4,   14, 13, 1, 11, 'hA1,      1, 1, 1, 0);
        vecs[15] = mk(0, 0, 0,           0, 0, 0,       14, 13, 1, 12, 'hA2,      1, 1, 1, 0);
        vecs[16] = mk(0, 0, 0,           0, 0, 0,       14, 13, 1, 13, 'hA3,      1, 1, 0, 0);
        vecs[17] = mk(0, 0, 0,           0, 0, 0,       14, 13, 1, 14, 'hA4,      1, 0, 0, 0);
        vecs[18] = mk(0, 0, 0,           0, 0, 0,       14, 13, 0, 0, 0,          1, 0, 0, 0);
        vecs[19] = mk(0, 0, 0,           1, 9, 'hAA,    9, 0,  0, 0, 0,           1, 1, 0, 0);
        vecs[20] = mk(1, 9, 'hBB,        0, 0, 0,       9, 0,  1, 9, 'hBB,        1, 0, 0, 0);
        vecs[21] = mk(0, 0, 0,           0, 0, 0,       9, 0,  0, 0, 0,           1, 0, 0, 0);
        vecs[22] = mk(0, 0, 0,           0, 0, 0,       9, 0,  0, 0, 0,           1, 0, 0, 0);
        vecs[23] = mk(1, 9, 'hDD,        1, 9, 'hCC,    9, 0,  1, 9, 'hDD,        1, 0, 0, 0);
        vecs[24] = mk(0, 0, 0,           0, 0, 0,       9, 0,  0, 0, 0,           1, 0, 0, 0);
        vecs[25] = mk(0, 0, 0,           1, 0, 'hEE,    0, 0,  0, 0, 0,           1, 0, 0, 0);
        vecs[26] = mk(0, 0, 0,           0, 0, 0,       0, 0,  0, 0, 0,           1, 0, 0, 0);
        vecs[27] = mk(0, 0, 0,           1, 4, 'h44,    4, 0,  0, 0, 0,           1, 1, 0, 0);
        vecs[28] = mk(1, 0, 'hFF,        0, 0, 0,       4, 0,  1, 4, 'h44,        1, 0, 0, 0);

        #12;
        chk("rst.regwrite", 32'(regwrite), 0);
        chk("rst.addr", 32'(REG_address_wb), 0);
        chk("rst.data", data_wb, 0);
        chk("rst.lu_ready", 32'(lu_ready), 1);
        chk("rst.stall", 32'(stall_req), 0);
        reset = 1'b1;

        for (int i = 0; i < 29; i++) begin
            drive(vecs[i]);
            step();
            chk($sformatf("v%0d.regwrite", i), 32'(regwrite), 32'(vecs[i].rw));
            if (vecs[i].rw) begin
                chk($sformatf("v%0d.addr", i), 32'(REG_address_wb), 32'(vecs[i].wa));
                chk($sformatf("v%0d.data", i), data_wb, vecs[i].wd);
            end
            chk($sformatf("v%0d.lu_ready", i), 32'(lu_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d.pend1", i), 32'(pend1), 32'(vecs[i].p1));
            chk($sformatf("v%0d.pend2", i), 32'(pend2), 32'(vecs[i].p2));
            chk($sformatf("v%0d.stall", i), 32'(stall_req), 32'(vecs[i].st));
        end

        // Starvation: one entry blocked behind a continuous pipeline stream.
        drive(mk(1, 2, 'h200, 1, 20, 'h5A, 20, 0, 0,0,0, 0,0,0,0));
        step();
        chk("starve.push_pend", 32'(pend1), 1);
        chk("starve.stall0", 32'(stall_req), 0);
        lu_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            pipe_wr_data = 32'h200 + 32'(k);
            step();
            chk($sformatf("starve.stall_c%0d", k), 32'(stall_req), (k == 9) ? 1 : 0);
            chk($sformatf("starve.pipe_c%0d", k), data_wb, 32'h200 + 32'(k));
        end
        pipe_wr_en = 1'b0;
        step();
        chk("starve.drain_rw", 32'(regwrite), 1);
        chk("starve.drain_addr", 32'(REG_address_wb), 20);
        chk("starve.drain_data", data_wb, 32'h5A);
        chk("starve.stall_hold", 32'(stall_req), 1);
        chk("starve.pend_clr", 32'(pend1), 0);
        step();
        chk("starve.stall_clr", 32'(stall_req), 0);
        chk("starve.idle_rw", 32'(regwrite), 0);

        // Reset in the middle of operation with three buffered entries.
        for (int k = 0; k < 3; k++) begin
            drive(mk(1, 1, 'h300 + k, 1, 21 + k, 'h70 + k, 22, 23, 0,0,0, 0,0,0,0));
            step();
        end
        chk("mid.pend1", 32'(pend1), 1);
        chk("mid.pend2", 32'(pend2), 1);
        chk("mid.regwrite", 32'(regwrite), 1);
        drive(mk(0, 0, 0, 0, 0, 0, 22, 23, 0,0,0, 0,0,0,0));
        reset = 1'b0;
        #1;
        chk("mid.rst_regwrite", 32'(regwrite), 0);
        chk("mid.rst_addr", 32'(REG_address_wb), 0);
        chk("mid.rst_data", data_wb, 0);
        chk("mid.rst_ready", 32'(lu_ready), 1);
        chk("mid.rst_pend1", 32'(pend1), 0);
        chk("mid.rst_pend2", 32'(pend2), 0);
        step();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("mid.post_rw%0d", k), 32'(regwrite), 0);
            chk($sformatf("mid.post_pend%0d", k), 32'(pend1 | pend2), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
